// File: rtl/ram_arb_pkg.sv
// Shared constants, response record and address check for the two-port SRAM arbiter.
package ram_arb_pkg;

  localparam int PORT_IFU = 0;
  localparam int PORT_LSU = 1;

  localparam int ARB_DW = 32;
  localparam int ARB_AW = 32;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [ARB_DW-1:0] rdata;
  } rsp_t;

  // Misaligned byte address, or word index beyond the SRAM depth.
  function automatic logic addr_err(input logic [ARB_AW-1:0] addr, input logic [ARB_AW-1:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[ARB_AW-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/ram_rsp_hold.sv
// Per-port response state: busy flag, fresh-read flag, error flag and read-data hold register.
module ram_rsp_hold
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              grant,
  input  logic              rd_ok,
  input  logic              err,
  input  logic              rsp_ready,
  input  logic [ARB_DW-1:0] ram_dout,
  output rsp_t              rsp
);

  logic              busy_q, busy_d;
  logic              fresh_q, fresh_d;
  logic              err_q, err_d;
  logic [ARB_DW-1:0] hold_q, hold_d;

  always_comb begin
    busy_d  = busy_q;
    fresh_d = 1'b0;
    err_d   = err_q;
    hold_d  = hold_q;
    if (grant) begin
      busy_d  = 1'b1;
      fresh_d = rd_ok;
      err_d   = err;
      hold_d  = '0;
    end else begin
      if (busy_q && rsp_ready) busy_d = 1'b0;
      // SRAM output is only valid for one cycle; keep it if the owner stalls.
      if (fresh_q && !rsp_ready) hold_d = ram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      fresh_q <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      fresh_q <= fresh_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    rsp.valid = busy_q;
    rsp.err   = busy_q && err_q;
    rsp.rdata = '0;
    if (busy_q) rsp.rdata = fresh_q ? ram_dout : hold_q;
  end

endmodule

// File: rtl/ram_port_arb.sv
// Shares one single-port SRAM between IFU (port 0) and LSU (port 1), one access per cycle.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int DP  = 512,
  parameter int DW  = 32,
  parameter int MW  = 4,
  parameter int AW  = 32,
  parameter int RAW = $clog2(DP)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [AW-1:0]  req0_addr,
  input  logic           req0_we,
  input  logic [MW-1:0]  req0_wem,
  input  logic [DW-1:0]  req0_wdata,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [DW-1:0]  rsp0_rdata,
  output logic           rsp0_err,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [AW-1:0]  req1_addr,
  input  logic           req1_we,
  input  logic [MW-1:0]  req1_wem,
  input  logic [DW-1:0]  req1_wdata,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp1_rdata,
  output logic           rsp1_err,
  output logic [RAW-1:0] ram_addr,
  output logic           ram_we,
  output logic [MW-1:0]  ram_wem,
  output logic [DW-1:0]  ram_din,
  input  logic [DW-1:0]  ram_dout
);

  localparam logic [AW-1:0] DEPTH = AW'(DP);

  logic [1:0]    req_valid, req_we, rsp_rdy, elig, grant, err, rd_ok;
  logic [AW-1:0] req_addr  [2];
  logic [MW-1:0] req_wem   [2];
  logic [DW-1:0] req_wdata [2];
  rsp_t          rsp       [2];
  logic          sel;

  assign req_valid = {req1_valid, req0_valid};
  assign req_we    = {req1_we, req0_we};
  assign rsp_rdy   = {rsp1_ready, rsp0_ready};
  assign req_addr[PORT_IFU]  = req0_addr;
  assign req_addr[PORT_LSU]  = req1_addr;
  assign req_wem[PORT_IFU]   = req0_wem;
  assign req_wem[PORT_LSU]   = req1_wem;
  assign req_wdata[PORT_IFU] = req0_wdata;
  assign req_wdata[PORT_LSU] = req1_wdata;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign err[gi]   = addr_err(req_addr[gi], DEPTH);
    // A port may reissue in the same cycle its previous response is consumed.
    assign elig[gi]  = !rst && req_valid[gi] && (!rsp[gi].valid || rsp_rdy[gi]);
    assign rd_ok[gi] = grant[gi] && !req_we[gi] && !err[gi];

    ram_rsp_hold u_hold (
      .clk       (clk),
      .rst       (rst),
      .grant     (grant[gi]),
      .rd_ok     (rd_ok[gi]),
      .err       (err[gi]),
      .rsp_ready (rsp_rdy[gi]),
      .ram_dout  (ram_dout),
      .rsp       (rsp[gi])
    );
  end

`ifdef RAM_ARB_RR_EN
  // last_q remembers the winner of the most recent tie; reset to 1 so port 0 wins first.
  logic last_q, last_d;

  always_comb begin
    grant  = elig;
    last_d = last_q;
    if (elig == 2'b11) begin
      grant  = last_q ? 2'b01 : 2'b10;
      last_d = ~last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = 2'b10;
  end
`endif

  always_comb begin
    sel      = grant[PORT_LSU];
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_wem  = '0;
    ram_din  = '0;
    if (|grant) begin
      ram_addr = req_addr[sel][RAW+1:2];
      if (req_we[sel] && !err[sel]) begin
        ram_we  = 1'b1;
        ram_wem = req_wem[sel];
        ram_din = req_wdata[sel];
      end
    end
  end

  assign req0_ready = grant[PORT_IFU];
  assign req1_ready = grant[PORT_LSU];
  assign rsp0_valid = rsp[PORT_IFU].valid;
  assign rsp0_err   = rsp[PORT_IFU].err;
  assign rsp0_rdata = rsp[PORT_IFU].rdata;
  assign rsp1_valid = rsp[PORT_LSU].valid;
  assign rsp1_err   = rsp[PORT_LSU].err;
  assign rsp1_rdata = rsp[PORT_LSU].rdata;

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb with a behavioural 512x32 byte-masked SRAM.
module tb_ram_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_ready, rsp0_err;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic [3:0]  req0_wem;
  logic        req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [3:0]  req1_wem;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din, ram_dout;

  int errors = 0;
  int checks = 0;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  ram_port_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_we(req0_we),
    .req0_wem(req0_wem), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_we(req1_we),
    .req1_wem(req1_wem), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, write-through onto dout so stale data would show up.
  logic [31:0] mem [0:511];
  logic [31:0] dout_q, merged;
  initial for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  always_comb begin
    merged = mem[ram_addr];
    for (int b = 0; b < 4; b++) if (ram_wem[b]) merged[8*b +: 8] = ram_din[8*b +: 8];
  end
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= merged;
      dout_q        <= merged;
    end else begin
      dout_q <= mem[ram_addr];
    end
  end
  assign ram_dout = dout_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  task automatic issue(input int p, input logic we, input logic [31:0] addr, input logic [3:0] wem,
                       input logic [31:0] wd, output logic we_seen);
    int n;
    @(negedge clk);
    if (p == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wem = wem; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wem = wem; req1_wdata = wd;
    end
    #1;
    n = 0;
    while (((p == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n == 20) begin errors++; $display("FAIL issue_timeout port=%0d: ready=0 required=1", p); end
    we_seen = ram_we;
    $display("txn port=%0d we=%0d addr=%h wem=%b wdata=%h ram_we=%0d", p, we, addr, wem, wd, ram_we);
    @(posedge clk); #1;
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] first;
    first = RR ? 2'b01 : 2'b10;
    rst = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0; req0_wem = 4'h0; req0_wdata = 32'h0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h0; req1_wem = 4'h0; req1_wdata = 32'h0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", {req1_ready, req0_ready}); end
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", {rsp1_valid, rsp0_valid}); end
    checks++; if ({rsp1_err, rsp0_err} !== 2'b00) begin errors++; $display("FAIL rst_rsp_err: got %b expected 00", {rsp1_err, rsp0_err}); end
    checks++; if (ram_we !== 1'b0 || ram_addr !== 9'h0) begin errors++; $display("FAIL rst_ram: we=%b addr=%h expected 0/0", ram_we, ram_addr); end
    checks++; if (rsp0_rdata !== 32'h0 || rsp1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h expected 0", rsp0_rdata, rsp1_rdata); end
    @(negedge clk); rst = 1'b0; #1;
    $display("txn reset released, both ports requesting, grant=%b", {req1_ready, req0_ready});
    checks++; if ({req1_ready, req0_ready} !== first) begin errors++; $display("FAIL first_grant: got %b expected %b", {req1_ready, req0_ready}, first); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if ({rsp1_valid, rsp0_valid} !== first) begin errors++; $display("FAIL first_rsp_valid: got %b expected %b", {rsp1_valid, rsp0_valid}, first); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin errors++; $display("FAIL midtxn_reset: rsp_valid=%b expected 00", {rsp1_valid, rsp0_valid}); end
    @(negedge clk); rst = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic test_write_read();
    logic ws;
    issue(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, ws);
    checks++; if (ws !== 1'b1) begin errors++; $display("FAIL wr_ram_we: got %b expected 1", ws); end
    checks++; if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b0 || rsp1_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp: valid=%b err=%b rdata=%h expected 1/0/0", rsp1_valid, rsp1_err, rsp1_rdata); end
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, ws);
    checks++; if (ws !== 1'b0) begin errors++; $display("FAIL rd_ram_we: got %b expected 0", ws); end
    checks++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b0) begin errors++; $display("FAIL rd_rsp: valid=%b err=%b expected 1/0", rsp0_valid, rsp0_err); end
    checks++; if (rsp0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h expected deadbeef", rsp0_rdata); end
  endtask

  task automatic test_byte_mask();
    logic ws;
    issue(1, 1'b1, 32'h10, 4'b0001, 32'h000000AA, ws);
    checks++; if (rsp1_err !== 1'b0) begin errors++; $display("FAIL mask_wr_err: got %b expected 0", rsp1_err); end
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, ws);
    checks++; if (rsp0_rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL mask_rdata: got %h expected deadbeaa", rsp0_rdata); end
  endtask

  task automatic test_errors();
    logic ws;
    issue(0, 1'b0, 32'h12, 4'h0, 32'h0, ws);
    checks++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_rdata !== 32'h0) begin errors++; $display("FAIL misalign_rsp: valid=%b err=%b rdata=%h expected 1/1/0", rsp0_valid, rsp0_err, rsp0_rdata); end
    issue(1, 1'b1, 32'h800, 4'hF, 32'h12345678, ws);
    checks++; if (ws !== 1'b0) begin errors++; $display("FAIL range_ram_we: got %b expected 0", ws); end
    checks++; if (rsp1_err !== 1'b1 || rsp1_rdata !== 32'h0) begin errors++; $display("FAIL range_rsp: err=%b rdata=%h expected 1/0", rsp1_err, rsp1_rdata); end
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0, ws);
    checks++; if (rsp0_err !== 1'b0 || rsp0_rdata !== 32'h0) begin errors++; $display("FAIL word0_intact: err=%b rdata=%h expected 0/0", rsp0_err, rsp0_rdata); end
  endtask

  task automatic test_backpressure();
    logic ws;
    @(posedge clk); #1; rsp0_ready = 1'b0;
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, ws);
    checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL bp_fresh: valid=%b rdata=%h expected 1/deadbeaa", rsp0_valid, rsp0_rdata); end
    issue(1, 1'b1, 32'h10, 4'hF, 32'h1, ws);
    checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL bp_hold_after_wr: valid=%b rdata=%h expected 1/deadbeaa", rsp0_valid, rsp0_rdata); end
    issue(1, 1'b0, 32'h10, 4'h0, 32'h0, ws);
    checks++; if (rsp1_rdata !== 32'h1) begin errors++; $display("FAIL bp_lsu_rdata: got %h expected 00000001", rsp1_rdata); end
    checks++; if (rsp0_rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL bp_hold_after_rd: got %h expected deadbeaa", rsp0_rdata); end
    @(negedge clk); rsp0_ready = 1'b1; #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL bp_handshake: valid=%b rdata=%h expected 1/deadbeaa", rsp0_valid, rsp0_rdata); end
    @(posedge clk); #1;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL bp_release: valid=%b expected 0", rsp0_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp   [3];
    addrs[0] = 32'h10; addrs[1] = 32'h0; addrs[2] = 32'h10;
    exp[0]   = 32'h1;  exp[1]   = 32'h0; exp[2]   = 32'h1;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = addrs[0];
    for (int i = 0; i < 3; i++) begin
      #1;
      $display("txn b2b port=0 addr=%h ready=%b", req0_addr, req0_ready);
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req0_ready); end
      @(posedge clk); #1;
      checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== exp[i]) begin errors++; $display("FAIL b2b_rsp[%0d]: valid=%b rdata=%h expected 1/%h", i, rsp0_valid, rsp0_rdata, exp[i]); end
      if (i < 2) req0_addr = addrs[i+1];
      else       req0_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g, prev_g;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h10;
    prev_g = 2'b00;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_g = RR ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b10;
      $display("txn contention cycle=%0d grant=%b", i, {req1_ready, req0_ready});
      checks++; if ({req1_ready, req0_ready} !== exp_g) begin errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, {req1_ready, req0_ready}, exp_g); end
      if (prev_g == 2'b01) begin
        checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h1) begin errors++; $display("FAIL contention_rsp0[%0d]: valid=%b rdata=%h expected 1/00000001", i, rsp0_valid, rsp0_rdata); end
      end else if (prev_g == 2'b10) begin
        checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h1) begin errors++; $display("FAIL contention_rsp1[%0d]: valid=%b rdata=%h expected 1/00000001", i, rsp1_valid, rsp1_rdata); end
      end
      prev_g = exp_g;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
